// File: rtl/gen_fs_en_nco.sv
// -----------------------------------------------------------------------------
// gen_fs_en_nco
//
// Fractional sample-enable generator. A modulo-SYS_FREQ_NUM phase accumulator
// advances by step = baud_num * STEP_MULT every cycle. Each time it wraps it
// emits one sub-tick. Every STEP_MULT sub-ticks form one symbol. The ticks
// leave through an OUT_DLY-deep pipeline followed by an output register.
//
// Ports
//   sys_clk    in   1      sole clock, rising edge
//   glb_rst_n  in   1      synchronous active-low reset
//   run        in   1      1 = generate ticks; 0 = hold phase at 0 and flush
//   baud_num   in   ACC_W  requested symbol rate in SYS_FREQ_NUM units
//   baud_vld   in   1      baud_num valid
//   baud_rdy   out  1      a new rate can be accepted (no update pending)
//   fs_en      out  1      single-cycle tick at STEP_MULT x symbol rate
//   fs_en_sym  out  1      tick on the first sub-tick of each symbol
//   sub_idx    out  4      sub-tick index of the most recent fs_en
//   rate_err   out  1      sticky: last offered rate was illegal
// -----------------------------------------------------------------------------
module gen_fs_en_nco #(
    parameter int unsigned      ACC_W        = 32,
    parameter logic [ACC_W-1:0] SYS_FREQ_NUM = 32'd10000,
    parameter int unsigned      STEP_MULT    = 2,   // 1..16
    parameter int unsigned      OUT_DLY      = 8    // 0..15
) (
    input  logic             sys_clk,
    input  logic             glb_rst_n,
    input  logic             run,
    input  logic [ACC_W-1:0] baud_num,
    input  logic             baud_vld,
    output logic             baud_rdy,
    output logic             fs_en,
    output logic             fs_en_sym,
    output logic [3:0]       sub_idx,
    output logic             rate_err
);

    localparam int unsigned CAND_W  = ACC_W + 4;
    localparam int unsigned PHASE_W = ACC_W + 1;
    localparam int unsigned SUM_W   = ACC_W + 2;

    localparam logic [CAND_W-1:0] MOD_CAND = CAND_W'(SYS_FREQ_NUM);
    localparam logic [SUM_W-1:0]  MOD_SUM  = SUM_W'(SYS_FREQ_NUM);
    localparam logic [CAND_W-1:0] MULT     = CAND_W'(STEP_MULT);
    localparam logic [3:0]        CNT_LAST = 4'(STEP_MULT - 1);

    // One pipeline slot: tick, symbol flag, sub-tick index travel together.
    typedef struct packed {
        logic       tick;
        logic       sym;
        logic [3:0] idx;
    } stage_t;

    logic [ACC_W-1:0]   step;
    logic [ACC_W-1:0]   pend_step;
    logic               pending;
    logic [CAND_W-1:0]  cand;
    logic               cand_ok;
    logic [PHASE_W-1:0] phase;
    logic [SUM_W-1:0]   sum;
    logic               wrap;
    logic               tick_pre;
    logic [3:0]         sub_cnt;
    stage_t             stage_in;
    stage_t             tap;

    // NOTE: every signal driven here gets a value on every path, so no latch.
    always_comb begin
        // Four guard bits hold baud_num * 16 without truncation, so an
        // oversized request is flagged instead of silently wrapping.
        cand     = CAND_W'(baud_num) * MULT;
        cand_ok  = (cand != '0) && (cand < MOD_CAND);
        sum      = SUM_W'(phase) + SUM_W'(step);
        wrap     = run && (step != '0) && (sum >= MOD_SUM);
        stage_in = '{tick: tick_pre, sym: tick_pre && (sub_cnt == 4'd0), idx: sub_cnt};
    end

    assign baud_rdy = ~pending;

    // Rate handshake. A pending step is held back until the accumulator wraps
    // so the symbol in progress finishes at the old rate; when the
    // accumulator is idle there is no wrap to wait for, so it lands at once.
    // The wrap sum itself was formed with the old step above.
    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (!glb_rst_n) begin
            step      <= '0;
            pend_step <= '0;
            pending   <= 1'b0;
            rate_err  <= 1'b0;
        end else if (pending) begin
            if (!run || (step == '0) || wrap) begin
                step    <= pend_step;
                pending <= 1'b0;
            end
        end else if (baud_vld) begin
            if (cand_ok) begin
                pend_step <= cand[ACC_W-1:0];
                pending   <= 1'b1;
                rate_err  <= 1'b0;
            end else begin
                rate_err  <= 1'b1;
            end
        end
    end

    // Phase accumulator and sub-tick counter.
    always_ff @(posedge sys_clk) begin
        if (!glb_rst_n || !run) begin
            phase    <= '0;
            tick_pre <= 1'b0;
            sub_cnt  <= 4'd0;
        end else begin
            if (step != '0) begin
                tick_pre <= wrap;
                phase    <= wrap ? PHASE_W'(sum - MOD_SUM) : PHASE_W'(sum);
            end else begin
                tick_pre <= 1'b0;
            end
            if (tick_pre) begin
                sub_cnt <= (sub_cnt == CNT_LAST) ? 4'd0 : sub_cnt + 4'd1;
            end
        end
    end

    // Delay line. It is cleared by run=0 as well as by reset so that no tick
    // already in flight can escape after the generator is stopped.
    if (OUT_DLY == 0) begin : g_no_dly
        assign tap = stage_in;
    end else begin : g_dly
        localparam int LAST = int'(OUT_DLY) - 1;
        stage_t dline [OUT_DLY];

        // NOTE: this delay line is flushed by reset on purpose; plain data
        // storage without that need would be left unreset.
        always_ff @(posedge sys_clk) begin
            if (!glb_rst_n || !run) begin
                for (int i = 0; i < int'(OUT_DLY); i++) dline[i] <= '0;
            end else begin
                dline[0] <= stage_in;
                for (int i = 1; i < int'(OUT_DLY); i++) dline[i] <= dline[i-1];
            end
        end

        assign tap = dline[LAST];
    end

    // Output register. sub_idx only moves with a tick so it reads as the
    // index of the most recent fs_en.
    always_ff @(posedge sys_clk) begin
        if (!glb_rst_n) begin
            fs_en     <= 1'b0;
            fs_en_sym <= 1'b0;
            sub_idx   <= 4'd0;
        end else if (!run) begin
            fs_en     <= 1'b0;
            fs_en_sym <= 1'b0;
        end else begin
            fs_en     <= tap.tick;
            fs_en_sym <= tap.sym;
            if (tap.tick) sub_idx <= tap.idx;
        end
    end

endmodule

// File: doc/gen_fs_en_nco.md
GEN_FS_EN_NCO -- requirements
Module: gen_fs_en_nco

Interface
REQ-001 Parameter ACC_W, default 32, phase accumulator and baud_num width.
REQ-002 Parameter SYS_FREQ_NUM, default 32'd10000, accumulator modulus (system clock frequency in baud_num units).
REQ-003 Parameter STEP_MULT, default 2, legal range 1..16, number of fs_en ticks per symbol.
REQ-004 Parameter OUT_DLY, default 8, legal range 0..15, extra output pipeline stages.
REQ-005 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-006 glb_rst_n  in  1  reset, synchronous, active-low.
REQ-007 run  in  1  1 = generate ticks; 0 = hold and flush.
REQ-008 baud_num  in  ACC_W  requested symbol rate (e.g. 2500 = 25 MBaud at SYS_FREQ_NUM 10000).
REQ-009 baud_vld  in  1  baud_num valid.
REQ-010 baud_rdy  out  1  block can accept a new rate.
REQ-011 fs_en  out  1  single-cycle tick at STEP_MULT x symbol rate.
REQ-012 fs_en_sym  out  1  single-cycle tick on the first sub-tick of each symbol.
REQ-013 sub_idx  out  4  sub-tick index (0..STEP_MULT-1) of current fs_en.
REQ-014 rate_err  out  1  sticky: last offered rate was illegal.

Function
REQ-015 Rate accept SHALL occur on a cycle with baud_vld=1 and baud_rdy=1; cand = baud_num*STEP_MULT computed at ACC_W+4 bits, no truncation.
REQ-016 cand==0 or cand>=SYS_FREQ_NUM SHALL be illegal: step unchanged, no pending update, rate_err<=1 next cycle.
REQ-017 Legal cand SHALL clear rate_err next cycle and become pending; baud_rdy SHALL be 0 while pending.
REQ-018 Pending step SHALL be applied on the same edge as the next accumulator wrap; if run=0 or active step==0, it SHALL be applied on the next edge.
REQ-019 Accumulator phase (ACC_W+1 bits) with run=1 and step!=0: sum=phase+step; sum>=SYS_FREQ_NUM -> phase<=sum-SYS_FREQ_NUM, tick_pre<=1; else phase<=sum, tick_pre<=0.
REQ-020 Wrap and pending-step apply on the same edge SHALL use the old step for that cycle's sum.
REQ-021 run=0 SHALL force phase<=0, tick_pre<=0, sub counter<=0, and clear all delay stages on the next edge; accepted/pending rate SHALL be retained.
REQ-022 Sub counter SHALL advance on each tick_pre, wrapping STEP_MULT-1 -> 0; a tick with counter 0 is a symbol tick.
REQ-023 fs_en, fs_en_sym, sub_idx SHALL equal tick_pre, symbol-tick flag, counter value delayed exactly OUT_DLY cycles (OUT_DLY=0: tick_pre registered directly); total latency from wrap-evaluation edge to fs_en = OUT_DLY+1 cycles.
REQ-024 fs_en_sym SHALL be asserted only together with fs_en; sub_idx SHALL hold its last value between ticks.
REQ-025 Long-run tick count SHALL be exact: over SYS_FREQ_NUM cycles at constant step, fs_en count = step; consecutive fs_en gaps SHALL differ by at most 1 cycle.
REQ-026 With STEP_MULT=1, every fs_en SHALL also assert fs_en_sym.

Reset
REQ-027 glb_rst_n=0 SHALL clear on next edge: step, pending, phase, sub counter, delay line, fs_en, fs_en_sym, sub_idx, rate_err to 0; baud_rdy to 1.
REQ-028 Reset mid-operation SHALL discard in-flight ticks; no fs_en for OUT_DLY+2 cycles after release even with run=1 and a new rate accepted.

Verification
REQ-029 Defaults, run=1, baud 2500 accepted: step 5000, fs_en every 2 cycles, fs_en_sym every 4 cycles, sub_idx alternates 0,1; first fs_en OUT_DLY+1 cycles after first wrap.
REQ-030 baud 1234: over 10000 cycles exactly 2468 fs_en and 1234 fs_en_sym; all fs_en gaps are 4 or 5 cycles.
REQ-031 Running at 2500, offer 1000: baud_rdy drops next cycle, rises after next wrap; gaps switch 2 -> 5 with no gap shorter than 2 or runt pulse.
REQ-032 Offer 5000 (cand 10000) then 0: rate_err=1 each time, old rate continues; then offer 2500: rate_err=0.
REQ-033 run 1->0 with ticks in flight: no fs_en from next cycle on; run 0->1: sub_idx restarts at 0, first fs_en_sym coincides with first fs_en.
REQ-034 Sweep OUT_DLY 0, 8, 15: latency wrap->fs_en = 1, 9, 16 cycles; reset pulse mid-run gives all outputs 0, baud_rdy=1.
